// File: rtl/series_job_sequencer.sv
// -----------------------------------------------------------------------------
// series_job_sequencer
//
// Feeds operands one at a time to the multi-cycle series-evaluation core.
// An operand accepted on the input stream is registered onto core_x and a
// one-cycle core_start pulse is issued. The sequencer then follows the core's
// ready/busy handshake: first it waits for the core to leave Idle, then for
// the core to return. When the core is back in Idle, its result is captured
// into a single-entry output slot that is drained over a valid/ready stream.
// A watchdog bounds each job. A hung job is abandoned and a sticky error is
// raised.
//
// Ports
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid / in_data  : operand stream in
//   in_ready            : operand stream ready. It is high only in IDLE and
//                         only while the core is ready.
//   core_start          : one-cycle start pulse to the core controller
//   core_x              : registered operand held for the core datapath
//   core_ready          : core controller ready (high while the core is idle)
//   core_result         : core result register
//   out_valid / out_data: result stream out, with backpressure
//   out_ready           : downstream accepts the result
//   timeout_err         : sticky; a job hit TIMEOUT
//   job_count           : number of captured results, modulo 2^CW
//   busy                : sequencer is not in IDLE
//
// TIMEOUT must satisfy 2 <= TIMEOUT < 2^TW.
// -----------------------------------------------------------------------------
module series_job_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             core_start,
    output logic [WIDTH-1:0] core_x,
    input  logic             core_ready,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             timeout_err,
    output logic [CW-1:0]    job_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             core_start_q, core_start_d;
    logic [WIDTH-1:0] core_x_q, core_x_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CW-1:0]    job_count_q, job_count_d;
    logic [TW-1:0]    wd_q, wd_d;

    // The output slot can take a new result when it is empty, or when it
    // is being drained on this same edge.
    logic slot_free;
    logic timed_out;

    assign slot_free = ~out_valid_q | out_ready;
    assign timed_out = (wd_q == TW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            core_start_q  <= 1'b0;
            core_x_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            timeout_err_q <= 1'b0;
            job_count_q   <= '0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            core_x_q      <= core_x_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            timeout_err_q <= timeout_err_d;
            job_count_q   <= job_count_d;
            wd_q          <= wd_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        core_start_d  = 1'b0;
        core_x_d      = core_x_q;
        // The slot drains on a handshake unless a capture below refills it.
        out_valid_d   = out_valid_q & ~out_ready;
        out_data_d    = out_data_q;
        timeout_err_d = timeout_err_q;
        job_count_d   = job_count_q;
        wd_d          = wd_q;

        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (in_valid && core_ready) begin
                    core_x_d     = in_data;
                    core_start_d = 1'b1;
                    state_d      = LAUNCH;
                end
            end

            LAUNCH: begin
                wd_d    = TW'(1);
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                if (timed_out) begin
                    timeout_err_d = 1'b1;
                    wd_d          = '0;
                    state_d       = IDLE;
                end else begin
                    wd_d = wd_q + TW'(1);
                    if (!core_ready) begin
                        state_d = WAIT_DONE;
                    end
                end
            end

            WAIT_DONE: begin
                // A capture takes priority over a timeout on the same cycle.
                // The result is already available in that case.
                if (core_ready && slot_free) begin
                    out_data_d  = core_result;
                    out_valid_d = 1'b1;
                    job_count_d = job_count_q + CW'(1);
                    wd_d        = '0;
                    state_d     = IDLE;
                end else if (timed_out) begin
                    timeout_err_d = 1'b1;
                    wd_d          = '0;
                    state_d       = IDLE;
                end else if (!core_ready) begin
                    // Count only while the core is still working. A stall
                    // on a full output slot is not charged to the job.
                    wd_d = wd_q + TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE) && core_ready;
    assign busy        = (state_q != IDLE);
    assign core_start  = core_start_q;
    assign core_x      = core_x_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;
    assign job_count   = job_count_q;

endmodule
